// File: rtl/chacha_stream_pkg.sv
// Shared widths, FSM state codes and block slicing helper for the ChaCha stream sequencer.
// The optional counters are enabled with CHACHA_STREAM_CTRL_PERF_EN in chacha_stream_ctrl.
package chacha_stream_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;
    localparam int WCNT_W          = 4;
    localparam int TIMEOUT_W       = 10;
    localparam int WORDS_PER_BLOCK = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FILL  = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;

    // Word 0 of a block lives in the most significant 32 bits.
    function automatic int word_msb(input int idx);
        return BLOCK_W - 1 - idx * WORD_W;
    endfunction

endpackage

// File: rtl/chacha_block_buf.sv
// 16x32 block register file: word writes from the input stream, whole-block loads from the core,
// clear, word-indexed read and a packed 512-bit view with word 0 in the MSBs.
module chacha_block_buf
    import chacha_stream_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               wr_en,
    input  logic [WCNT_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic [WCNT_W-1:0]  rd_idx,
    output logic [WORD_W-1:0]  rd_data,
    output logic [BLOCK_W-1:0] block
);

    logic [WORD_W-1:0] mem [WORDS_PER_BLOCK];

    // Clear wins over load, load over word write; the sequencer never asserts two at once.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                mem[i] <= load_data[word_msb(i) -: WORD_W];
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_pack
        assign block[word_msb(g) -: WORD_W] = mem[g];
    end

endmodule

// File: rtl/chacha_stream_ctrl.sv
// Streams 32-bit words through the ChaCha core: fill a block, pulse init/next, wait, drain.
// Define CHACHA_STREAM_CTRL_PERF_EN to add the perf_blocks/perf_stall counters.
module chacha_stream_ctrl
    import chacha_stream_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               msg_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    output logic               core_init,
    output logic               core_next,
    output logic [BLOCK_W-1:0] core_data_in,
    input  logic               core_ready,
    input  logic [BLOCK_W-1:0] core_data_out,
    input  logic               core_data_out_valid,
    output logic               busy,
    output logic               error
`ifdef CHACHA_STREAM_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_blocks,
    output logic [31:0]        perf_stall
`endif
);

    // Handshakes: a word moves on a rising clk edge where valid & ready are both high;
    // the producer holds data/last stable while valid & !ready.

    state_t               state;
    logic [WCNT_W-1:0]    wcnt;
    logic [WCNT_W-1:0]    rcnt;
    logic [WCNT_W-1:0]    last_idx;
    logic                 last_blk;
    logic                 first_blk;
    logic                 wait_first;
    logic [TIMEOUT_W-1:0] tcnt;

    logic in_hs;
    logic start_go;
    logic wait_done;
    logic wait_to;
    logic drain_hs;
    logic drain_end;
    logic buf_clear;
    logic msg_go;

    assign msg_go    = (state == ST_IDLE) & msg_start;
    assign in_ready  = (state == ST_FILL);
    assign in_hs     = in_ready & in_valid;
    assign start_go  = (state == ST_START) & core_ready;
    assign core_init = start_go & first_blk;
    assign core_next = start_go & ~first_blk;

    // The core lowers core_ready one cycle after the pulse, so the first WAIT cycle is skipped.
    assign wait_done = (state == ST_WAIT) & ~wait_first & core_ready & core_data_out_valid;
    assign wait_to   = (state == ST_WAIT) & ~wait_done & (tcnt == TIMEOUT_W'(WAIT_TIMEOUT));

    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid & last_blk & (rcnt == last_idx);
    assign drain_hs  = out_valid & out_ready;
    assign drain_end = drain_hs & (rcnt == last_idx);
    assign busy      = (state != ST_IDLE);

    assign buf_clear = msg_go | wait_to | (drain_end & ~last_blk);

    chacha_block_buf u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (buf_clear),
        .load      (wait_done),
        .load_data (core_data_out),
        .wr_en     (in_hs),
        .wr_idx    (wcnt),
        .wr_data   (in_data),
        .rd_idx    (rcnt),
        .rd_data   (out_data),
        .block     (core_data_in)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            rcnt       <= '0;
            last_idx   <= '0;
            last_blk   <= 1'b0;
            first_blk  <= 1'b1;
            wait_first <= 1'b0;
            tcnt       <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (msg_start) begin
                        state     <= ST_FILL;
                        first_blk <= 1'b1;
                        error     <= 1'b0;
                        wcnt      <= '0;
                    end
                end
                ST_FILL: begin
                    if (in_hs) begin
                        wcnt <= wcnt + 1'b1;
                        // in_last on the 16th word closes a full block, never a 17th slot.
                        if (wcnt == WCNT_W'(WORDS_PER_BLOCK - 1) || in_last) begin
                            state    <= ST_START;
                            last_idx <= wcnt;
                            last_blk <= in_last;
                        end
                    end
                end
                ST_START: begin
                    if (core_ready) begin
                        state      <= ST_WAIT;
                        first_blk  <= 1'b0;
                        tcnt       <= '0;
                        wait_first <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    wait_first <= 1'b0;
                    if (wait_done) begin
                        state <= ST_DRAIN;
                        rcnt  <= '0;
                    end else if (wait_to) begin
                        state <= ST_IDLE;
                        error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        if (last_blk) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_FILL;
                            wcnt  <= '0;
                        end
                    end else if (drain_hs) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CHACHA_STREAM_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n || msg_go) begin
            perf_blocks <= '0;
            perf_stall  <= '0;
        end else begin
            if (drain_end && perf_blocks != '1) begin
                perf_blocks <= perf_blocks + 1'b1;
            end
            if (out_valid && !out_ready && perf_stall != '1) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Directed/randomized bench for chacha_stream_ctrl with a behavioural ChaCha core stand-in.
// Ciphertext is predicted as plaintext[j] ^ ks(j / 16, j % 16) from the message alone.
module tb_chacha_stream_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         msg_start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_data_in;
    logic         core_ready = 1'b1;
    logic [511:0] core_data_out = '0;
    logic         core_data_out_valid = 1'b0;
    logic         busy;
    logic         error;
`ifdef CHACHA_STREAM_CTRL_PERF_EN
    logic [31:0]  perf_blocks;
    logic [31:0]  perf_stall;
`endif

    chacha_stream_ctrl dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .msg_start           (msg_start),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_last             (in_last),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .core_init           (core_init),
        .core_next           (core_next),
        .core_data_in        (core_data_in),
        .core_ready          (core_ready),
        .core_data_out       (core_data_out),
        .core_data_out_valid (core_data_out_valid),
        .busy                (busy),
        .error               (error)
`ifdef CHACHA_STREAM_CTRL_PERF_EN
        ,
        .perf_blocks         (perf_blocks),
        .perf_stall          (perf_stall)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    logic [31:0]  pt_q[$];
    logic [31:0]  exp_q[$];
    logic [31:0]  got_q[$];
    logic         last_q[$];
    int           pulse_kind_q[$];
    logic [511:0] pulse_blk_q[$];

    int   stall_cnt;
    int   stable_err;
    int   extra;
    int   drive_to;
    logic busy_after;
    int   viol = 0;

    function automatic logic [31:0] ks(input int blk, input int w);
        return 32'hA5C3_0F1E ^ (32'(blk) * 32'h9E37_79B9) ^ (32'(w + 1) * 32'h85EB_CA6B);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural core ----------------
    int           core_lat = 20;
    logic         core_hang = 1'b0;
    int           core_cnt = 0;
    int           core_ctr = 0;
    logic         core_drop = 1'b0;
    logic [511:0] core_cap = '0;

    always @(negedge clk) begin
        if ((core_init && core_next) || ((core_init || core_next) && in_ready)) viol++;
        if (!reset_n) begin
            core_ready = 1'b1;
            core_data_out_valid = 1'b0;
            core_drop = 1'b0;
            core_cnt = 0;
        end else if (core_init || core_next) begin
            pulse_kind_q.push_back(core_init ? 1 : 2);
            pulse_blk_q.push_back(core_data_in);
            core_cap = core_data_in;
            core_ctr = core_init ? 0 : core_ctr + 1;
            core_data_out_valid = 1'b0;
            core_drop = 1'b1;
            core_cnt = core_lat;
        end else if (core_drop) begin
            core_ready = 1'b0;
            core_drop = 1'b0;
        end else if (!core_ready && !core_hang) begin
            if (core_cnt > 0) begin
                core_cnt--;
            end else begin
                for (int w = 0; w < 16; w++) begin
                    core_data_out[511 - 32 * w -: 32] = core_cap[511 - 32 * w -: 32] ^ ks(core_ctr, w);
                end
                core_ready = 1'b1;
                core_data_out_valid = 1'b1;
            end
        end
    end

    // ---------------- driver / collector ----------------
    task automatic drive_words();
        int budget;
        drive_to = 0;
        for (int j = 0; j < pt_q.size(); j++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = pt_q[j];
            in_last  = (j == pt_q.size() - 1);
            budget = 0;
            while (!in_ready && budget < 3000) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                drive_to++;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int n, input int mode);
        int budget;
        int ph;
        logic held;
        logic [31:0] held_d;
        logic held_l;
        budget = 0;
        ph = 0;
        held = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (got_q.size() < n && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (held && (!out_valid || out_data !== held_d || out_last !== held_l)) stable_err++;
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    if (out_valid) ph++;
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (out_valid && !out_ready) stall_cnt++;
            held   = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
            end
        end
        @(negedge clk);
        busy_after = busy;
        out_ready = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
    endtask

    task automatic make_msg(input int n, input int kind);
        pt_q.delete();
        exp_q.delete();
        for (int j = 0; j < n; j++) begin
            case (kind)
                0: pt_q.push_back(32'(j));
                1: pt_q.push_back($urandom);
                default: pt_q.push_back(32'hDEAD_BEEF);
            endcase
            exp_q.push_back(pt_q[j] ^ ks(j / 16, j % 16));
        end
    endtask

    task automatic pulse_start();
        msg_start = 1'b1;
        @(negedge clk);
        msg_start = 1'b0;
    endtask

    // Full message: start, stream in, collect out, then check everything against the model.
    task automatic run_msg(input int n, input int kind, input int mode, input int lat);
        int nb;
        int lasts;
        logic [511:0] blk;
        logic [31:0] expw;
        core_lat = lat;
        make_msg(n, kind);
        got_q.delete();
        last_q.delete();
        pulse_kind_q.delete();
        pulse_blk_q.delete();
        stall_cnt = 0;
        stable_err = 0;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_error_clear", 32'(error), 32'd0);
        fork
            drive_words();
            collect(n, mode);
        join
        nb = (n + 15) / 16;
        chk("drive_timeout", 32'(drive_to), 32'd0);
        chk("out_count", 32'(got_q.size()), 32'(n));
        for (int j = 0; j < got_q.size() && j < n; j++) begin
            chk($sformatf("out_word%0d", j), got_q[j], exp_q[j]);
        end
        lasts = 0;
        foreach (last_q[j]) if (last_q[j]) lasts++;
        chk("out_last_count", 32'(lasts), 32'd1);
        if (last_q.size() == n) chk("out_last_final", 32'(last_q[n - 1]), 32'd1);
        chk("busy_after_last", 32'(busy_after), 32'd0);
        chk("extra_outputs", 32'(extra), 32'd0);
        chk("stable_while_stalled", 32'(stable_err), 32'd0);
        chk("pulse_count", 32'(pulse_kind_q.size()), 32'(nb));
        for (int b = 0; b < pulse_kind_q.size() && b < nb; b++) begin
            chk($sformatf("pulse_kind%0d", b), 32'(pulse_kind_q[b]), (b == 0) ? 32'd1 : 32'd2);
            blk = pulse_blk_q[b];
            for (int w = 0; w < 16; w++) begin
                expw = (b * 16 + w < n) ? pt_q[b * 16 + w] : 32'd0;
                chk($sformatf("blk%0d_word%0d", b, w), blk[511 - 32 * w -: 32], expw);
            end
        end
`ifdef CHACHA_STREAM_CTRL_PERF_EN
        chk("perf_blocks", perf_blocks, 32'(nb));
        chk("perf_stall", perf_stall, 32'(stall_cnt));
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int budget;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_pulses", 32'({core_init, core_next}), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_core_data_in_zero", 32'(core_data_in == '0), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // one full block with in_last on word 16, sequential data
        run_msg(16, 0, 0, 20);
        // three blocks, last one short, random backpressure
        run_msg(40, 1, 2, 20);
        // single word message
        run_msg(1, 2, 0, 20);
        // sink toggling 1-0-0-1
        run_msg(24, 1, 1, 5);

        // core hangs: timeout, ignored msg_start while busy, recovery with init
        core_hang = 1'b1;
        core_lat = 8;
        make_msg(16, 1);
        pulse_start();
        drive_words();
        repeat (500) @(negedge clk);
        pulse_start();
        chk("ignored_start_in_ready", 32'(in_ready), 32'd0);
        chk("ignored_start_busy", 32'(busy), 32'd1);
        repeat (499) @(negedge clk);
        chk("pre_timeout_error", 32'(error), 32'd0);
        budget = 0;
        while (!error && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_idle", 32'(busy), 32'd0);
        core_hang = 1'b0;
        run_msg(16, 1, 2, 20);

        // reset while waiting on the core, then a clean message
        core_lat = 200;
        make_msg(16, 1);
        pulse_start();
        drive_words();
        repeat (20) @(negedge clk);
        chk("mid_wait_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_pulses", 32'({core_init, core_next}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_msg(16, 1, 0, 20);

        // random length, random sink
        run_msg($urandom_range(2, 48), 1, 2, 12);

        chk("pulse_overlap_violations", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
